cmd_unit_host: RTL and testbench

- Host side of the unit command interface: drives cmd/cmd_ready/arg_data into one command unit (e.g. the system unit) and collects its param_write/cmd_done response.
- Consumes a framed 32-bit command stream from the command parser. Buffers the arguments, issues the command, then captures parameter words plus the response code.
- Emits one framed response packet per command toward the response serializer.
- Times out a unit that never asserts cmd_done.

---
 rtl/cmd_if_pkg.sv | 40 ++++
 rtl/cmd_unit_host_word_buf.sv | 27 ++
 rtl/cmd_unit_host.sv | 203 ++++++++++++++++++++
 tb/tb_cmd_unit_host.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_if_pkg.sv
// Shared definitions for the unit command interface: header/response field positions,
// FSM state encoding and the response header packer.
package cmd_if_pkg;

  localparam int unsigned HdrCmdLsb    = 0;
  localparam int unsigned HdrNargsLsb  = 16;
  localparam int unsigned HdrNargsMsb  = 23;

  localparam int unsigned RspTmoBit    = 31;
  localparam int unsigned RspPrmOvfBit = 30;
  localparam int unsigned RspArgOvfBit = 29;
  localparam int unsigned RspCntLsb    = 16;
  localparam int unsigned RspCntMsb    = 23;
  localparam int unsigned RspCodeW     = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArgs    = 3'd1,
    StIssue   = 3'd2,
    StWait    = 3'd3,
    StRspHdr  = 3'd4,
    StRspBody = 3'd5
  } state_e;

  function automatic logic [31:0] rsp_header(input logic                tmo,
                                             input logic                prm_ovf,
                                             input logic                arg_ovf,
                                             input logic [7:0]          cnt,
                                             input logic [RspCodeW-1:0] code);
    logic [31:0] w;
    w                         = '0;
    w[RspTmoBit]              = tmo;
    w[RspPrmOvfBit]           = prm_ovf;
    w[RspArgOvfBit]           = arg_ovf;
    w[RspCntMsb:RspCntLsb]    = cnt;
    w[RspCodeW-1:0]           = code;
    return w;
  endfunction

endpackage

// File: rtl/cmd_unit_host_word_buf.sv
// Register file of 32-bit words: synchronous write, combinational indexed read.
module word_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cmd_unit_host.sv
// Host side of the unit command interface: buffers a framed command, issues it to one unit,
// collects parameter words and the response code, and emits one framed response packet.
module cmd_unit_host
  import cmd_if_pkg::*;
#(
  parameter int unsigned CMD_BITS   = 8,
  parameter int unsigned MAX_ARGS   = 8,
  parameter int unsigned MAX_PARAMS = 8,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CMD_BITS-1:0] cmd,
  output logic                cmd_ready,
  output logic [31:0]         arg_data,
  input  logic                arg_advance,
  input  logic                cmd_done,
  input  logic [31:0]         param_data,
  input  logic                param_write,
  output logic [31:0]         rsp_data,
  output logic                rsp_valid,
  output logic                rsp_last,
  input  logic                rsp_ready,
  output logic                busy
);

  localparam int unsigned AAW  = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;
  localparam int unsigned PAW  = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
  localparam int unsigned RdW  = $clog2(MAX_ARGS + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d, code_q, code_d;
  logic [7:0]          nargs_q, nargs_d, arg_wr_q, arg_wr_d;
  logic [RdW-1:0]      arg_rd_q, arg_rd_d;
  logic [7:0]          prm_cnt_q, prm_cnt_d, rsp_idx_q, rsp_idx_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                tmo_q, tmo_d, arg_ovf_q, arg_ovf_d, prm_ovf_q, prm_ovf_d;

  logic        accept, arg_we, prm_we;
  logic [31:0] arg_rdata, prm_rdata;
  logic [7:0]  stored_cnt;

  word_buf #(.DEPTH(MAX_ARGS)) u_arg_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (arg_we),
    .waddr_i (AAW'(arg_wr_q)),
    .wdata_i (in_data),
    .raddr_i (AAW'(arg_rd_q)),
    .rdata_o (arg_rdata)
  );

  word_buf #(.DEPTH(MAX_PARAMS)) u_prm_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (prm_we),
    .waddr_i (PAW'(prm_cnt_q)),
    .wdata_i (param_data),
    .raddr_i (PAW'(rsp_idx_q)),
    .rdata_o (prm_rdata)
  );

  // in_ready is gated by rst so every output reads 0 while reset is held.
  assign in_ready   = !rst && (state_q == StIdle || state_q == StArgs);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != StIdle);
  assign cmd        = cmd_q;
  assign stored_cnt = (32'(prm_cnt_q) < MAX_PARAMS) ? prm_cnt_q : 8'(MAX_PARAMS);
  assign arg_data   = (32'(arg_rd_q) < 32'(nargs_q) && 32'(arg_rd_q) < MAX_ARGS) ? arg_rdata : '0;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    code_d    = code_q;
    nargs_d   = nargs_q;
    arg_wr_d  = arg_wr_q;
    arg_rd_d  = arg_rd_q;
    prm_cnt_d = prm_cnt_q;
    rsp_idx_d = rsp_idx_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
    arg_ovf_d = arg_ovf_q;
    prm_ovf_d = prm_ovf_q;
    arg_we    = 1'b0;
    prm_we    = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_data  = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cmd_d     = in_data[HdrCmdLsb +: CMD_BITS];
          nargs_d   = in_data[HdrNargsMsb:HdrNargsLsb];
          code_d    = '0;
          arg_wr_d  = '0;
          arg_rd_d  = '0;
          prm_cnt_d = '0;
          rsp_idx_d = '0;
          tmo_cnt_d = '0;
          tmo_d     = 1'b0;
          arg_ovf_d = 1'b0;
          prm_ovf_d = 1'b0;
          state_d   = (in_data[HdrNargsMsb:HdrNargsLsb] == 8'd0) ? StIssue : StArgs;
        end
      end
      StArgs: begin
        if (accept) begin
          if (32'(arg_wr_q) < MAX_ARGS) arg_we = 1'b1;
          else                          arg_ovf_d = 1'b1;
          arg_wr_d = arg_wr_q + 8'd1;
          if (arg_wr_q == nargs_q - 8'd1) state_d = StIssue;
        end
      end
      StIssue: begin
        cmd_ready = 1'b1;
        tmo_cnt_d = TmoW'(1);
        state_d   = StWait;
      end
      StWait: begin
        if (cmd_done) begin
          code_d  = param_data[CMD_BITS-1:0];
          state_d = StRspHdr;
        end else begin
          if (param_write) begin
            if (32'(prm_cnt_q) < MAX_PARAMS) prm_we = 1'b1;
            else                             prm_ovf_d = 1'b1;
            if (prm_cnt_q != 8'hFF) prm_cnt_d = prm_cnt_q + 8'd1;
          end
          // The counter is 0 in the issue cycle, so this fires TIMEOUT cycles after cmd_ready.
          if (tmo_cnt_q == TmoLast) begin
            tmo_d     = 1'b1;
            code_d    = '0;
            prm_cnt_d = '0;
            state_d   = StRspHdr;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
          end
        end
      end
      StRspHdr: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_header(tmo_q, prm_ovf_q, arg_ovf_q, stored_cnt, RspCodeW'(code_q));
        rsp_last  = (stored_cnt == 8'd0);
        if (rsp_ready) begin
          rsp_idx_d = '0;
          state_d   = rsp_last ? StIdle : StRspBody;
        end
      end
      StRspBody: begin
        rsp_valid = 1'b1;
        rsp_data  = prm_rdata;
        rsp_last  = (rsp_idx_q == stored_cnt - 8'd1);
        if (rsp_ready) begin
          if (rsp_last) state_d = StIdle;
          else          rsp_idx_d = rsp_idx_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StIssue || state_q == StWait) && arg_advance && 32'(arg_rd_q) < MAX_ARGS) begin
      arg_rd_d = arg_rd_q + RdW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      code_q    <= '0;
      nargs_q   <= '0;
      arg_wr_q  <= '0;
      arg_rd_q  <= '0;
      prm_cnt_q <= '0;
      rsp_idx_q <= '0;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
      arg_ovf_q <= 1'b0;
      prm_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      code_q    <= code_d;
      nargs_q   <= nargs_d;
      arg_wr_q  <= arg_wr_d;
      arg_rd_q  <= arg_rd_d;
      prm_cnt_q <= prm_cnt_d;
      rsp_idx_q <= rsp_idx_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      arg_ovf_q <= arg_ovf_d;
      prm_ovf_q <= prm_ovf_d;
    end
  end

endmodule

// File: tb/tb_cmd_unit_host.sv
// Scoreboard bench for cmd_unit_host: directed commands push expected response words,
// a monitor pops and compares on every response handshake.
module tb_cmd_unit_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  cmd;
  logic        cmd_ready;
  logic [31:0] arg_data;
  logic        arg_advance = 1'b0;
  logic        cmd_done = 1'b0;
  logic [31:0] param_data = '0;
  logic        param_write = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_last;
  logic        rsp_ready = 1'b1;
  logic        busy;

  cmd_unit_host #(
    .CMD_BITS   (8),
    .MAX_ARGS   (8),
    .MAX_PARAMS (8),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .arg_data    (arg_data),
    .arg_advance (arg_advance),
    .cmd_done    (cmd_done),
    .param_data  (param_data),
    .param_write (param_write),
    .rsp_data    (rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_last    (rsp_last),
    .rsp_ready   (rsp_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic last);
    rsp_t e;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_rsp: got 0x%08h, expected no word", rsp_data);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk_b("rsp_last", rsp_last, e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL send_word: in_ready 0 for 50 cycles, word 0x%08h not accepted", w);
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_cmd_ready(output int at);
    bit ok = 1'b0;
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL wait_cmd_ready: got no pulse in 200 cycles, expected one");
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk_b({name, "_idle"}, ok, 1'b1);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_issue;
    int t_rsp;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk_b("rst_rsp_valid", rsp_valid, 1'b0);
    chk_b("rst_cmd_ready", cmd_ready, 1'b0);
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_arg_data", arg_data, 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_b("idle_in_ready", in_ready, 1'b1);
    tick();

    // 1: nargs=0, two params, code 0
    push(32'h0002_0000, 1'b0);
    push(32'h0000_0001, 1'b0);
    push(32'h0102_0304, 1'b1);
    send_word(32'h0000_0000);
    @(negedge clk);
    chk_b("t1_cmd_ready_latency", cmd_ready, 1'b1);
    tick();
    param_write = 1'b1;
    param_data  = 32'h0000_0001;
    tick();
    param_data  = 32'h0102_0304;
    tick();
    param_write = 1'b0;
    cmd_done    = 1'b1;
    param_data  = 32'h0;
    tick();
    cmd_done    = 1'b0;
    @(negedge clk);
    chk_b("t1_rsp_latency", rsp_valid, 1'b1);
    wait_idle("t1");

    // 2: two args walked with arg_advance held; done with simultaneous param_write
    arg_advance = 1'b1;
    push(32'h0000_0007, 1'b1);
    send_word(32'h0002_0005);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    @(negedge clk);
    chk_b("t2_cmd_ready", cmd_ready, 1'b1);
    chk("t2_cmd", 32'(cmd), 32'h05);
    chk("t2_arg0", arg_data, 32'h1111_1111);
    tick();
    @(negedge clk);
    chk("t2_arg1", arg_data, 32'h2222_2222);
    tick();
    @(negedge clk);
    chk("t2_arg_end", arg_data, 32'h0);
    tick();
    param_write = 1'b1;
    cmd_done    = 1'b1;
    param_data  = 32'h0000_0007;
    tick();
    param_write = 1'b0;
    cmd_done    = 1'b0;
    param_data  = 32'h0;
    arg_advance = 1'b0;
    wait_idle("t2");

    // 3: nargs=10 overflows the 8-deep arg buffer
    push(32'h2000_0033, 1'b1);
    send_word(32'h000A_0003);
    for (int i = 0; i < 10; i++) send_word(32'hA000_0000 + 32'(i));
    @(negedge clk);
    chk_b("t3_cmd_ready", cmd_ready, 1'b1);
    chk("t3_arg0", arg_data, 32'hA000_0000);
    tick();
    cmd_done   = 1'b1;
    param_data = 32'h0000_0033;
    tick();
    cmd_done   = 1'b0;
    param_data = 32'h0;
    wait_idle("t3");

    // 4: nine params overflow the 8-deep param buffer
    push(32'h4008_0044, 1'b0);
    for (int i = 0; i < 8; i++) push(32'hB000_0000 + 32'(i), (i == 7));
    send_word(32'h0000_0004);
    wait_cmd_ready(t_issue);
    tick();
    param_write = 1'b1;
    for (int i = 0; i < 9; i++) begin
      param_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    param_write = 1'b0;
    cmd_done    = 1'b1;
    param_data  = 32'h0000_0044;
    tick();
    cmd_done    = 1'b0;
    param_data  = 32'h0;
    wait_idle("t4");

    // 5: timeout; params written before it are discarded
    push(32'h8000_0000, 1'b1);
    send_word(32'h0000_0009);
    wait_cmd_ready(t_issue);
    tick();
    param_write = 1'b1;
    param_data  = 32'hC000_0001;
    tick();
    param_data  = 32'hC000_0002;
    tick();
    param_write = 1'b0;
    param_data  = 32'h0;
    t_rsp = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        t_rsp = cyc;
        break;
      end
    end
    chk("t5_timeout_cycles", 32'(t_rsp - t_issue), 32'd16);
    wait_idle("t5");
    chk_b("t5_busy_after", busy, 1'b0);

    // 6: stall mid-body, then reset abandons the packet
    rsp_ready = 1'b0;
    push(32'h0003_0001, 1'b0);
    push(32'hD000_0000, 1'b0);
    send_word(32'h0000_000A);
    wait_cmd_ready(t_issue);
    tick();
    param_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      param_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    param_write = 1'b0;
    cmd_done    = 1'b1;
    param_data  = 32'h0000_0001;
    tick();
    cmd_done    = 1'b0;
    param_data  = 32'h0;
    rsp_ready   = 1'b1;
    tick();
    tick();
    rsp_ready   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_b("t6_stall_valid", rsp_valid, 1'b1);
      chk("t6_stall_data", rsp_data, 32'hD000_0001);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_b("t6_rst_rsp_valid", rsp_valid, 1'b0);
    chk_b("t6_rst_rsp_last", rsp_last, 1'b0);
    chk_b("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rsp_data", rsp_data, 32'h0);
    chk("t6_rst_cmd", 32'(cmd), 32'h0);
    chk("t6_rst_queue", 32'(exp_q.size()), 32'd0);
    rsp_ready = 1'b1;
    tick();
    push(32'h0000_0002, 1'b1);
    in_data  = 32'h0000_000B;
    in_valid = 1'b1;
    @(negedge clk);
    chk_b("t6_new_hdr_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = 32'h0;
    @(negedge clk);
    chk_b("t6_new_cmd_ready", cmd_ready, 1'b1);
    chk("t6_new_cmd", 32'(cmd), 32'h0B);
    tick();
    cmd_done   = 1'b1;
    param_data = 32'h0000_0002;
    tick();
    cmd_done   = 1'b0;
    param_data = 32'h0;
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
